// File: rtl/can_tx_bit_stuffer.sv
// can_tx_bit_stuffer: CAN TX stuff-bit insertion with transmitter stall strobe; optional bus monitor under CAN_TX_BIT_MONITOR_EN
module can_tx_bit_stuffer #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_point,
  input  logic             tx_bit_in,
  input  logic             stuff_en,
  input  logic             arbitration_active,
  input  logic             rx_bit,
  output logic             tx_sample_point,
  output logic             tx_bit_out,
  output logic             stuff_active,
  output logic [CNT_W-1:0] stuff_cnt,
  output logic             bit_err,
  output logic             arb_lost
);
  localparam logic [2:0] RUN_MAX = 3'(STUFF_LEN);
  logic       last_bit;
  logic       window;
  logic       stuff_now;
  logic [2:0] same_cnt;
  assign stuff_now = window & (same_cnt == RUN_MAX);
  assign tx_sample_point = sample_point & ~stuff_now & ~rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_bit_out <= 1'b1;
      last_bit <= 1'b1;
      stuff_active <= 1'b0;
      stuff_cnt <= '0;
      same_cnt <= '0;
      window <= 1'b0;
    end else if (sample_point) begin
      if (stuff_now) begin
        tx_bit_out <= ~last_bit;
        last_bit <= ~last_bit;
        same_cnt <= 3'd1;
        stuff_active <= 1'b1;
        stuff_cnt <= &stuff_cnt ? stuff_cnt : stuff_cnt + 1'b1;
      end else begin
        tx_bit_out <= tx_bit_in;
        last_bit <= tx_bit_in;
        stuff_active <= 1'b0;
        window <= stuff_en;
        same_cnt <= !stuff_en ? 3'd0 : !window ? 3'd1 : (tx_bit_in == last_bit) ? same_cnt + 3'd1 : 3'd1;
        if (stuff_en && !window)
          stuff_cnt <= '0;
      end
    end
  end
`ifdef CAN_TX_BIT_MONITOR_EN
  logic lost_now;
  assign lost_now = arbitration_active & tx_bit_out & ~rx_bit;
  always_ff @(posedge clk) begin
    if (rst) begin
      arb_lost <= 1'b0;
      bit_err <= 1'b0;
    end else begin
      arb_lost <= sample_point & lost_now;
      bit_err <= sample_point & ~lost_now & window & (rx_bit ^ tx_bit_out);
    end
  end
`else
  logic unused_mon;
  assign unused_mon = rx_bit ^ arbitration_active;
  assign bit_err = 1'b0;
  assign arb_lost = 1'b0;
`endif
endmodule
